// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: access sizes, IO map, HEX width.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [15:0] IO_LEDR = 16'h7000;
  localparam logic [15:0] IO_LEDG = 16'h7010;
  localparam logic [15:0] IO_HEX  = 16'h7020;
  localparam logic [15:0] IO_LCD  = 16'h7030;
  localparam logic [15:0] IO_SW   = 16'h7800;
  localparam logic [15:0] IO_BTN  = 16'h7810;

  localparam int HEX_W = 7;
endpackage

// File: rtl/lsu_dmem.sv
// Single-port byte-enable data RAM, synchronous read-first.
module lsu_dmem #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit with data RAM and readback IO block.
// Define LSU_IO_SYNC_EN to add 2-flop synchronisers on switches/buttons.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int DMEM_DEPTH = 2048,
  parameter int DMEM_BASE  = 32'h2000,
  parameter int ADDR_W     = 16,
  parameter int N_HEX      = 8,
  parameter int BTN_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  output logic               o_ready,
  input  logic               i_we,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  output logic               o_rvalid,
  output logic [31:0]        o_rdata,
  output logic               o_misaligned,
  output logic [31:0]        o_io_ledr,
  output logic [31:0]        o_io_ledg,
  output logic [31:0]        o_io_lcd,
  output logic [7*N_HEX-1:0] o_io_hex,
  input  logic [31:0]        i_io_sw,
  input  logic [BTN_W-1:0]   i_io_btn
);
  localparam int AW = $clog2(DMEM_DEPTH);
  localparam logic [31:0] BASE = DMEM_BASE;

  logic              acc, wr, mis, is_h, is_w;
  logic [ADDR_W-1:0] a, win;
  logic [1:0]        lo;
  logic              ram_hit, h_ledr, h_ledg, h_hex, h_lcd, h_sw, h_btn;
  logic [3:0]        be;
  logic [31:0]       wrep, io_word, ram_rd;
  logic [31:0]       ledr, ledg, lcd, sw_v;
  logic [BTN_W-1:0]  btn_v;
  logic [HEX_W-1:0]  hex_q [N_HEX];
  logic [63:0]       hex_rd;
  logic              unused_addr;

  assign o_ready = rst_n;
  assign acc     = i_req & rst_n;
  assign a       = i_addr[ADDR_W-1:0];
  assign lo      = a[1:0];
  assign win     = {a[ADDR_W-1:4], 4'h0};
  assign is_w    = i_size[1];
  assign is_h    = (i_size == SZ_H);
  assign mis     = (is_h & lo[0]) | (is_w & (lo != 2'b00));
  assign wr      = acc & i_we & ~mis;
  assign unused_addr = ^i_addr[31:ADDR_W];

  assign ram_hit = a[ADDR_W-1:AW+2] == BASE[ADDR_W-1:AW+2];
  assign h_ledr  = win == ADDR_W'(IO_LEDR);
  assign h_ledg  = win == ADDR_W'(IO_LEDG);
  assign h_hex   = win == ADDR_W'(IO_HEX);
  assign h_lcd   = win == ADDR_W'(IO_LCD);
  assign h_sw    = win == ADDR_W'(IO_SW);
  assign h_btn   = win == ADDR_W'(IO_BTN);

  // Lane enables plus store data replicated into every lane
  always_comb begin
    be   = 4'b0000;
    wrep = i_wdata;
    unique case (1'b1)
      is_w: begin
        be   = 4'b1111;
        wrep = i_wdata;
      end
      is_h: begin
        be   = lo[1] ? 4'b1100 : 4'b0011;
        wrep = {2{i_wdata[15:0]}};
      end
      default: begin
        be   = 4'b0001 << lo;
        wrep = {4{i_wdata[7:0]}};
      end
    endcase
  end

  lsu_dmem #(.DEPTH(DMEM_DEPTH), .AW(AW)) u_dmem (
    .clk   (clk),
    .we    (wr & ram_hit),
    .be    (be),
    .addr  (a[AW+1:2]),
    .wdata (wrep),
    .rdata (ram_rd)
  );

`ifdef LSU_IO_SYNC_EN
  logic [31:0]      sw_s1, sw_s2;
  logic [BTN_W-1:0] btn_s1, btn_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= i_io_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_io_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign sw_v  = sw_s2;
  assign btn_v = btn_s2;
`else
  assign sw_v  = i_io_sw;
  assign btn_v = i_io_btn;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      for (int k = 0; k < N_HEX; k++) hex_q[k] <= '0;
    end else if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b] && h_ledr) ledr[8*b +: 8] <= wrep[8*b +: 8];
        if (be[b] && h_ledg) ledg[8*b +: 8] <= wrep[8*b +: 8];
        if (be[b] && h_lcd)  lcd[8*b +: 8]  <= wrep[8*b +: 8];
      end
      for (int k = 0; k < N_HEX; k++) begin
        if (h_hex && be[k%4] && ((k / 4) == int'(a[2])))
          hex_q[k] <= wrep[8*(k%4) +: HEX_W];
      end
    end
  end

  always_comb begin
    hex_rd   = '0;
    o_io_hex = '0;
    for (int k = 0; k < N_HEX; k++) begin
      hex_rd[8*k +: HEX_W]   = hex_q[k];
      o_io_hex[7*k +: HEX_W] = hex_q[k];
    end
    io_word = '0;
    unique case (1'b1)
      h_ledr:  io_word = ledr;
      h_ledg:  io_word = ledg;
      h_lcd:   io_word = lcd;
      h_hex:   io_word = a[2] ? hex_rd[63:32] : hex_rd[31:0];
      h_sw:    io_word = sw_v;
      h_btn:   io_word[BTN_W-1:0] = btn_v;
      default: io_word = '0;
    endcase
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;

  logic        rv_q, mis_q, ld_q, ram_q, uns_q;
  logic [1:0]  lo_q, sz_q;
  logic [31:0] io_q, word, sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv_q  <= 1'b0;
      mis_q <= 1'b0;
      ld_q  <= 1'b0;
      ram_q <= 1'b0;
      uns_q <= 1'b0;
      lo_q  <= '0;
      sz_q  <= '0;
      io_q  <= '0;
    end else begin
      rv_q  <= acc;
      mis_q <= acc & mis;
      ld_q  <= acc & ~i_we & ~mis;
      ram_q <= ram_hit;
      uns_q <= i_unsigned;
      lo_q  <= lo;
      sz_q  <= i_size;
      io_q  <= io_word;
    end
  end

  // RAM word arrives from the synchronous read; steer and extend it here
  always_comb begin
    word = ram_q ? ram_rd : io_q;
    sh   = word >> {lo_q, 3'b000};
    o_rdata = '0;
    unique case (1'b1)
      sz_q[1]:        o_rdata = sh;
      sz_q == SZ_H:   o_rdata = {{16{~uns_q & sh[15]}}, sh[15:0]};
      default:        o_rdata = {{24{~uns_q & sh[7]}}, sh[7:0]};
    endcase
    if (!ld_q) o_rdata = '0;
  end

  assign o_rvalid     = rv_q;
  assign o_misaligned = mis_q;
endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio with a byte-level reference model.
module tb_lsu_mmio;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0, i_unsigned = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic [31:0] i_addr = '0, i_wdata = '0, i_io_sw = '0;
  logic [3:0]  i_io_btn = '0;
  logic        o_ready, o_rvalid, o_misaligned;
  logic [31:0] o_rdata, o_io_ledr, o_io_ledg, o_io_lcd;
  logic [55:0] o_io_hex;

  lsu_mmio dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .o_ready(o_ready),
    .i_we(i_we), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rvalid(o_rvalid),
    .o_rdata(o_rdata), .o_misaligned(o_misaligned),
    .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg), .o_io_lcd(o_io_lcd),
    .o_io_hex(o_io_hex), .i_io_sw(i_io_sw), .i_io_btn(i_io_btn)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void ck(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  mram [int];
  logic [31:0] m_ledr = '0, m_ledg = '0, m_lcd = '0;
  logic [6:0]  m_hex [8];
  logic        m_v = 1'b0, m_mis = 1'b0;
  logic [31:0] m_d = '0;
  logic [31:0] m_swv = '0;
  logic [3:0]  m_btv = '0;
  logic [31:0] sw_h [2];
  logic [3:0]  btn_h [2];

  function automatic logic [55:0] mhex();
    logic [55:0] r;
    for (int k = 0; k < 8; k++) r[7*k +: 7] = m_hex[k];
    return r;
  endfunction

  function automatic logic is_ram(int a);
    return a >= 'h2000 && a < 'h4000;
  endfunction

  function automatic void wr_byte(int a, logic [7:0] b);
    int s = 8 * (a % 4);
    int d = ((a >> 2) & 1) * 4 + a % 4;
    if (is_ram(a)) mram[a] = b;
    else case (a >> 4)
      'h700: m_ledr[s +: 8] = b;
      'h701: m_ledg[s +: 8] = b;
      'h703: m_lcd[s +: 8] = b;
      'h702: m_hex[d] = b[6:0];
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] rd_byte(int a);
    int s = 8 * (a % 4);
    int d = ((a >> 2) & 1) * 4 + a % 4;
    if (is_ram(a)) return mram.exists(a) ? mram[a] : 8'h00;
    case (a >> 4)
      'h700: return m_ledr[s +: 8];
      'h701: return m_ledg[s +: 8];
      'h703: return m_lcd[s +: 8];
      'h702: return {1'b0, m_hex[d]};
      'h780: return m_swv[s +: 8];
      'h781: return (s == 0) ? {4'h0, m_btv} : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_op();
    int a = int'(i_addr[15:0]);
    int n = (i_size == 2'b00) ? 1 : (i_size == 2'b01) ? 2 : 4;
    logic [31:0] v = '0;
    if (a % n != 0) begin
      m_mis = 1'b1;
      return;
    end
    if (i_we) begin
      for (int i = 0; i < n; i++) wr_byte(a + i, 8'(i_wdata >> (8 * i)));
    end else begin
      for (int i = 0; i < n; i++) v = v | (32'(rd_byte(a + i)) << (8 * i));
      if (!i_unsigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      m_d = v;
    end
  endfunction

  always @(posedge clk) begin
`ifdef LSU_IO_SYNC_EN
    m_swv = sw_h[1];
    m_btv = btn_h[1];
`else
    m_swv = i_io_sw;
    m_btv = i_io_btn;
`endif
    m_v = 1'b0;
    m_mis = 1'b0;
    m_d = '0;
    if (!rst_n) begin
      m_ledr = '0;
      m_ledg = '0;
      m_lcd = '0;
      for (int k = 0; k < 8; k++) m_hex[k] = '0;
      sw_h[0] = '0; sw_h[1] = '0;
      btn_h[0] = '0; btn_h[1] = '0;
    end else begin
      m_v = i_req;
      if (i_req) model_op();
      sw_h[1] = sw_h[0]; sw_h[0] = i_io_sw;
      btn_h[1] = btn_h[0]; btn_h[0] = i_io_btn;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    ck("rvalid", 64'(o_rvalid), 64'(m_v));
    if (m_v) begin
      ck("rdata", 64'(o_rdata), 64'(m_d));
      ck("misaligned", 64'(o_misaligned), 64'(m_mis));
    end
    ck("ledr", 64'(o_io_ledr), 64'(m_ledr));
    ck("ledg", 64'(o_io_ledg), 64'(m_ledg));
    ck("lcd", 64'(o_io_lcd), 64'(m_lcd));
    ck("hex", 64'(o_io_hex), 64'(mhex()));
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns;
    i_addr = ad; i_wdata = wd;
  endtask

  task automatic idle();
    @(negedge clk);
    i_req = 1'b0; i_we = 1'b0;
  endtask

  task automatic resp(input string nm, input logic [31:0] d, input logic mi);
    ck({nm, "_v"}, 64'(o_rvalid), 64'(1));
    ck({nm, "_d"}, 64'(o_rdata), 64'(d));
    ck({nm, "_m"}, 64'(o_misaligned), 64'(mi));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    idle(); idle();
    ck("rst_rvalid", 64'(o_rvalid), 64'(0));
    ck("rst_rdata", 64'(o_rdata), 64'(0));
    ck("rst_mis", 64'(o_misaligned), 64'(0));
    ck("rst_ledr", 64'(o_io_ledr), 64'(0));
    ck("rst_hex", 64'(o_io_hex), 64'(0));
    rst_n = 1'b1;
    ck("ready", 64'(o_ready), 64'(1));

    op(1, 2'b10, 0, 32'h2004, 32'hDEADBEEF); idle();
    ck("sw_nodata", 64'(o_rdata), 64'(0));
    op(0, 2'b00, 0, 32'h2007, 0); idle(); resp("lb", 32'hFFFFFFDE, 0);
    op(0, 2'b00, 1, 32'h2007, 0); idle(); resp("lbu", 32'h000000DE, 0);
    op(0, 2'b01, 0, 32'h2006, 0); idle(); resp("lh", 32'hFFFFDEAD, 0);

    op(1, 2'b10, 0, 32'h2000, 32'h11223344);
    op(1, 2'b00, 0, 32'h2001, 32'h000000AA);
    op(0, 2'b10, 0, 32'h2000, 0); idle(); resp("merge", 32'h1122AA44, 0);
    op(1, 2'b10, 0, 32'h2010, 32'hCAFEF00D);
    op(0, 2'b10, 0, 32'h2010, 0); idle(); resp("raw", 32'hCAFEF00D, 0);

    op(0, 2'b01, 0, 32'h2001, 0); idle(); resp("mis_lh", 0, 1);
    op(1, 2'b10, 0, 32'h2002, 32'hFFFFFFFF); idle(); resp("mis_sw", 0, 1);
    op(0, 2'b10, 0, 32'h2000, 0); idle(); resp("unchanged", 32'h1122AA44, 0);
    op(0, 2'b10, 0, 32'h12342000, 0); idle(); resp("hi_addr", 32'h1122AA44, 0);

    op(1, 2'b10, 0, 32'h7020, 32'h01020304);
    op(1, 2'b10, 0, 32'h7024, 32'h7F7F7F7F); idle();
    ck("hex_digits", 64'(o_io_hex),
       64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h01, 7'h02, 7'h03, 7'h04}));
    op(0, 2'b10, 0, 32'h7024, 0); idle(); resp("hex_hi", 32'h7F7F7F7F, 0);
    op(1, 2'b00, 0, 32'h7021, 32'h000000FF);
    op(0, 2'b10, 0, 32'h7020, 0); idle(); resp("hex_lo", 32'h01027F04, 0);

    op(1, 2'b00, 0, 32'h7002, 32'h0000005A);
    op(0, 2'b10, 0, 32'h7000, 0); idle(); resp("ledr", 32'h005A0000, 0);
    op(1, 2'b01, 0, 32'h7012, 32'h0000BEEF); idle();
    ck("ledg", 64'(o_io_ledg), 64'(32'hBEEF0000));
    op(1, 2'b10, 0, 32'h7038, 32'h12345678); idle();
    ck("lcd_alias", 64'(o_io_lcd), 64'(32'h12345678));

    op(1, 2'b10, 0, 32'h5000, 32'h99999999);
    op(0, 2'b10, 0, 32'h5000, 0); idle(); resp("unmapped", 0, 0);

    i_io_sw = 32'h0000A5A5; i_io_btn = 4'b1010;
    idle(); idle();
    op(0, 2'b10, 0, 32'h7800, 0); idle(); resp("sw_in", 32'h0000A5A5, 0);
    op(0, 2'b10, 0, 32'h7810, 0); idle(); resp("btn_in", 32'h0000000A, 0);
    op(0, 2'b00, 0, 32'h7801, 0); idle(); resp("sw_lb", 32'hFFFFFFA5, 0);
    op(1, 2'b10, 0, 32'h7800, 32'h0); idle();

`ifdef LSU_IO_SYNC_EN
    idle(); i_io_sw = 32'h00005555;
    op(0, 2'b10, 0, 32'h7800, 0);
    op(0, 2'b10, 0, 32'h7800, 0);
    resp("sync_old", 32'h0000A5A5, 0);
    idle(); resp("sync_new", 32'h00005555, 0);
`else
    @(negedge clk);
    i_io_sw = 32'h00001234;
    i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_addr = 32'h7800;
    idle(); resp("direct_in", 32'h00001234, 0);
`endif

    op(1, 2'b10, 0, 32'h2020, 32'h55667788);
    op(1, 2'b10, 0, 32'h7000, 32'hFFFF0000);
    @(negedge clk);
    i_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    ck("drop_rvalid", 64'(o_rvalid), 64'(0));
    ck("drop_ledr", 64'(o_io_ledr), 64'(0));
    i_req = 1'b1; i_we = 1'b1; i_size = 2'b10;
    i_addr = 32'h2020; i_wdata = 32'h0BADF00D;
    @(negedge clk);
    i_req = 1'b0; rst_n = 1'b1;
    op(0, 2'b10, 0, 32'h2020, 0); idle(); resp("ram_kept", 32'h55667788, 0);
    op(0, 2'b10, 0, 32'h7000, 0); idle(); resp("ledr_rst", 32'h0, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
